// File: rtl/package_settings.sv
// package_settings: project-wide settings shared by the ADC emulation blocks.
package package_settings;
    localparam int SIZE_ADC_DATA = 14;
endpackage

// File: rtl/pulse_gen_parameter.sv
// pulse_gen_parameter: state encoding and default shaping constants for adc_pulse_gen.
package pulse_gen_parameter;
    typedef enum logic [1:0] {IDLE, RISE, DECAY, HOLD} pulse_state_t;
    localparam int DEFAULT_BASELINE    = 100;
    localparam int DEFAULT_RISE_SHIFT  = 2;
    localparam int DEFAULT_DECAY_SHIFT = 4;
    localparam int DEFAULT_HOLDOFF     = 16;
    localparam int FRAC_W              = 8;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
endpackage

// File: rtl/pulse_gen_lfsr.sv
// pulse_gen_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) exposing its 3 LSBs as raw noise.
module pulse_gen_lfsr
    import pulse_gen_parameter::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] noise
);
    logic [15:0] q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= LFSR_SEED;
        else        q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    assign noise = q[2:0];
endmodule

// File: rtl/adc_pulse_gen.sv
// adc_pulse_gen: emulated ADC pulse (linear rise, exponential decay, holdoff) on a baseline.
// Define ADC_PULSE_GEN_NOISE_EN to add LFSR noise of -4..+3 counts to every sample.
module adc_pulse_gen
    import package_settings::*;
    import pulse_gen_parameter::*;
#(
    parameter int BASELINE    = DEFAULT_BASELINE,
    parameter int RISE_SHIFT  = DEFAULT_RISE_SHIFT,
    parameter int DECAY_SHIFT = DEFAULT_DECAY_SHIFT,
    parameter int HOLDOFF     = DEFAULT_HOLDOFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    output logic                     trig_ack,
    output logic                     busy,
    output logic [7:0]               miss_cnt,
    output logic [SIZE_ADC_DATA-1:0] output_data
);
    localparam int ACC_W    = SIZE_ADC_DATA + FRAC_W;
    localparam int ADC_MAX  = (1 << SIZE_ADC_DATA) - 1;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int CNT_W    = $clog2((RISE_LEN > HOLDOFF ? RISE_LEN : HOLDOFF) + 1);
    localparam int SW       = SIZE_ADC_DATA + 3;

    pulse_state_t state, state_next;
    logic [ACC_W-1:0] acc, peak, step, decr;
    logic [CNT_W-1:0] cnt;
    logic [SIZE_ADC_DATA-1:0] amp, sample;
    logic signed [SW-1:0] level, noise_s;
    logic tail_done;

    assign peak      = {amp, {FRAC_W{1'b0}}};
    assign step      = peak >> RISE_SHIFT;
    assign tail_done = acc[ACC_W-1:FRAC_W] == '0;

`ifdef ADC_PULSE_GEN_NOISE_EN
    logic [2:0] noise;
    pulse_gen_lfsr u_lfsr (.clk(clk), .reset(reset), .noise(noise));
    assign noise_s = SW'($signed({1'b0, noise}) - 4'sd4);
`else
    assign noise_s = '0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = trig ? RISE : IDLE;
            RISE:    state_next = cnt == CNT_W'(1) ? DECAY : RISE;
            DECAY:   state_next = tail_done ? HOLD : DECAY;
            HOLD:    state_next = cnt == '0 ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    // level is signed so negative noise below a zero baseline clamps instead of wrapping
    always_comb begin
        busy   = state != IDLE;
        decr   = (acc >> DECAY_SHIFT) == '0 ? ACC_W'(1) : acc >> DECAY_SHIFT;
        level  = SW'(BASELINE) + SW'(acc[ACC_W-1:FRAC_W]) + noise_s;
        sample = level[SW-1] ? '0 : level > SW'(ADC_MAX) ? SIZE_ADC_DATA'(ADC_MAX) : level[SIZE_ADC_DATA-1:0];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc         <= '0;
            cnt         <= '0;
            amp         <= '0;
            trig_ack    <= 1'b0;
            miss_cnt    <= '0;
            output_data <= '0;
        end else begin
            trig_ack    <= state == IDLE && trig;
            output_data <= sample;
            if (busy && trig && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            case (state)
                IDLE: if (trig) begin
                    amp <= amplitude;
                    acc <= '0;
                    cnt <= CNT_W'(RISE_LEN);
                end
                RISE: begin
                    acc <= cnt == CNT_W'(1) ? peak : acc + step;
                    cnt <= cnt - 1'b1;
                end
                DECAY: if (tail_done) begin
                    acc <= '0;
                    cnt <= CNT_W'(HOLDOFF);
                end else acc <= acc - decr;
                HOLD: cnt <= cnt == '0 ? cnt : cnt - 1'b1;
                default: acc <= '0;
            endcase
        end
endmodule

// File: tb/tb_adc_pulse_gen.sv
// tb_adc_pulse_gen: scoreboard bench for adc_pulse_gen; stimulus queues expected samples, a monitor checks them.
module tb_adc_pulse_gen;
    import package_settings::*;
    localparam int BASE = 100, RS = 2, DS = 4, HO = 16, MAXV = (1 << SIZE_ADC_DATA) - 1;
    typedef struct { int out; bit ack; bit busy; } exp_t;

    logic clk = 0, reset, trig, trig_ack, busy;
    logic [SIZE_ADC_DATA-1:0] amplitude, output_data;
    logic [7:0] miss_cnt;
    exp_t sb[$];
    int checks = 0, errors = 0;
    bit active = 0;

    adc_pulse_gen dut (
        .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude),
        .trig_ack(trig_ack), .busy(busy), .miss_cnt(miss_cnt), .output_data(output_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v > MAXV ? MAXV : v;
    endfunction

    // Sample k is taken at the k-th falling edge after acceptance (k=0 carries trig_ack)
    task automatic push_pulse(input int amp, input int first_k);
        int av[$];
        int acc, dcy, n;
        av.push_back(0);
        av.push_back(0);
        for (int i = 1; i <= (1 << RS); i++)
            av.push_back(i == (1 << RS) ? amp << 8 : i * ((amp << 8) >> RS));
        acc = amp << 8;
        n = 0;
        while ((acc >> 8) != 0) begin
            dcy = acc >> DS;
            acc -= (dcy == 0) ? 1 : dcy;
            av.push_back(acc);
            n++;
        end
        for (int k = first_k; k <= 6 + n + HO; k++)
            sb.push_back('{sat(BASE + ((k < av.size() ? av[k] : 0) >> 8)), k == 0, k <= 5 + n + HO});
    endtask

    task automatic fire(input int amp);
        @(negedge clk);
        trig = 1;
        amplitude = SIZE_ADC_DATA'(amp);
        @(negedge clk);
        trig = 0;
        amplitude = SIZE_ADC_DATA'(12345);
    endtask

    // mode 0: scoreboard drained, 1: busy low
    task automatic wait_until(input int mode, input int limit);
        int n = 0;
        while (!(mode == 0 ? sb.size() == 0 : !busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(mode == 0 ? "drain_timeout" : "idle_timeout", int'(mode == 0 ? sb.size() == 0 : !busy), 1);
        if (mode == 0) sb.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) active = 0;
        else if (sb.size() > 0 && (active || trig_ack)) begin
            e = sb.pop_front();
            active = 1;
            check("output_data", int'(output_data), e.out);
            check("trig_ack", int'(trig_ack), int'(e.ack));
            check("busy", int'(busy), int'(e.busy));
            if (sb.size() == 0) active = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int head[8] = '{100, 100, 350, 600, 850, 1100, 1037, 978};
        int first_run[32];
        reset = 1;
        trig = 0;
        amplitude = '0;
        #1 reset = 0;
        #2;
        check("reset_output_data", int'(output_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_ack", int'(trig_ack), 0);
        check("reset_miss_cnt", int'(miss_cnt), 0);
        @(negedge clk);
        #2 reset = 1;
`ifdef ADC_PULSE_GEN_NOISE_EN
        trig = 1;
        amplitude = '0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            reset = 0;
            @(negedge clk);
            #2 reset = 1;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                check("noise_range", int'(output_data >= 96 && output_data <= 103), 1);
                if (r == 0) first_run[i] = int'(output_data);
                else check("noise_repeat", int'(output_data), first_run[i]);
            end
        end
        trig = 0;
`else
        @(negedge clk);
        check("baseline_after_reset", int'(output_data), BASE);
        check("idle_busy", int'(busy), 0);
        for (int k = 0; k < 8; k++) sb.push_back('{head[k], k == 0, 1'b1});
        push_pulse(1000, 8);
        fire(1000);
        wait_until(0, 400);
        push_pulse(1000, 0);
        fire(1000);
        repeat (10) @(negedge clk);
        repeat (3) begin
            trig = 1;
            @(negedge clk);
            trig = 0;
            @(negedge clk);
        end
        wait_until(0, 400);
        check("miss_cnt_3", int'(miss_cnt), 3);
        push_pulse(16383, 0);
        fire(16383);
        wait_until(0, 400);
        push_pulse(0, 0);
        fire(0);
        wait_until(0, 100);
        repeat (3) push_pulse(1000, 0);
        @(negedge clk);
        trig = 1;
        amplitude = SIZE_ADC_DATA'(1000);
        wait_until(0, 1000);
        trig = 0;
        wait_until(1, 400);
        check("miss_cnt_saturated", int'(miss_cnt), 255);
        fire(1000);
        check("ver4_trig_ack", int'(trig_ack), 1);
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        check("midrise_reset_output_data", int'(output_data), 0);
        check("midrise_reset_busy", int'(busy), 0);
        check("midrise_reset_trig_ack", int'(trig_ack), 0);
        check("midrise_reset_miss_cnt", int'(miss_cnt), 0);
        @(negedge clk);
        #2 reset = 1;
        @(negedge clk);
        check("release_baseline", int'(output_data), BASE);
        check("release_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("no_residual_tail", int'(output_data), BASE);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
